// File: rtl/conv2d_engine.sv
`timescale 1ns/1ps
// conv2d_engine: fixed-point 2-D convolution engine with internal activation
// and weight stores. A run walks every output pixel of every output channel.
// Each pixel is accumulated one product per cycle and then offered on a
// valid/ready port. The result is shifted, saturated and optionally ReLU'd.
module conv2d_engine #(
  parameter int DATA_W      = 16,
  parameter int FRAC_W      = 8,
  parameter int ACC_W       = 40,
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_OUTPUTS = 2,
  parameter int INPUT_DIM   = 5,
  parameter int KERNEL_DIM  = 3,
  parameter int STRIDE      = 1,
  parameter int RELU        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [15:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       out_ch,
  output logic [15:0]       out_y,
  output logic [15:0]       out_x
);

  localparam int OUTPUT_DIM = (INPUT_DIM - KERNEL_DIM) / STRIDE + 1;
  localparam int ACT_N      = NUM_INPUTS * INPUT_DIM * INPUT_DIM;
  localparam int WGT_N      = NUM_OUTPUTS * NUM_INPUTS * KERNEL_DIM * KERNEL_DIM;
  localparam int ACT_AW     = (ACT_N > 1) ? $clog2(ACT_N) : 1;
  localparam int WGT_AW     = (WGT_N > 1) ? $clog2(WGT_N) : 1;
  localparam int PROD_W     = 2 * DATA_W;

  // Loop limits as 16-bit constants to match the index counters.
  localparam logic [15:0] K_LAST  = 16'(KERNEL_DIM - 1);
  localparam logic [15:0] CI_LAST = 16'(NUM_INPUTS - 1);
  localparam logic [15:0] CO_LAST = 16'(NUM_OUTPUTS - 1);
  localparam logic [15:0] O_LAST  = 16'(OUTPUT_DIM - 1);

  // 32-bit factors for the linear address arithmetic.
  localparam logic [31:0] D_32  = 32'(INPUT_DIM);
  localparam logic [31:0] D2_32 = 32'(INPUT_DIM * INPUT_DIM);
  localparam logic [31:0] K_32  = 32'(KERNEL_DIM);
  localparam logic [31:0] S_32  = 32'(STRIDE);
  localparam logic [31:0] NI_32 = 32'(NUM_INPUTS);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]               r_state;
  logic [15:0]              r_co, r_oy, r_ox, r_ci, r_ky, r_kx;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]        r_out_data;
  logic [15:0]              r_out_ch, r_out_y, r_out_x;

  logic signed [DATA_W-1:0] r_act [ACT_N];
  logic signed [DATA_W-1:0] r_wgt [WGT_N];

  logic [ACT_AW-1:0]        w_act_idx;
  logic [WGT_AW-1:0]        w_wgt_idx;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W-1:0]  w_shift;
  logic [DATA_W-1:0]        w_result;

  // Store write port: only accepted while idle and inside the store bounds.
  // NOTE: the stores carry no reset; their contents must survive rst_n and a
  // reset branch would also stop them mapping onto plain register files.
  always_ff @(posedge clk) begin
    if (wr_en && r_state == S_IDLE) begin
      if (!wr_sel && {16'd0, wr_addr} < 32'(ACT_N))
        r_act[ACT_AW'(wr_addr)] <= wr_data;
      else if (wr_sel && {16'd0, wr_addr} < 32'(WGT_N))
        r_wgt[WGT_AW'(wr_addr)] <= wr_data;
    end
  end

  // Operand fetch, multiply-accumulate and result formatting for the current tap.
  always_comb begin
    // NOTE: every variable gets a value before any conditional assignment,
    // so no path can leave one unassigned and infer a latch.
    w_result   = '0;
    w_act_idx  = ACT_AW'({16'd0, r_ci} * D2_32
                         + ({16'd0, r_oy} * S_32 + {16'd0, r_ky}) * D_32
                         + {16'd0, r_ox} * S_32 + {16'd0, r_kx});
    w_wgt_idx  = WGT_AW'((({16'd0, r_co} * NI_32 + {16'd0, r_ci}) * K_32
                          + {16'd0, r_ky}) * K_32 + {16'd0, r_kx});
    w_prod     = PROD_W'(r_act[w_act_idx]) * PROD_W'(r_wgt[w_wgt_idx]);
    w_acc_next = r_acc + ACC_W'(w_prod);
    w_shift    = w_acc_next >>> FRAC_W;
    if (w_shift > SAT_MAX)
      w_result = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_shift < SAT_MIN)
      w_result = {1'b1, {(DATA_W-1){1'b0}}};
    else
      w_result = w_shift[DATA_W-1:0];
    if (RELU != 0 && w_result[DATA_W-1])
      w_result = '0;
  end

  // Control FSM, loop counters, accumulator and the held output register.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_co       <= '0;
      r_oy       <= '0;
      r_ox       <= '0;
      r_ci       <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_ch   <= '0;
      r_out_y    <= '0;
      r_out_x    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_co    <= '0;
            r_oy    <= '0;
            r_ox    <= '0;
            r_ci    <= '0;
            r_ky    <= '0;
            r_kx    <= '0;
            r_acc   <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (r_kx != K_LAST) begin
            r_kx <= r_kx + 16'd1;
          end else begin
            r_kx <= '0;
            if (r_ky != K_LAST) begin
              r_ky <= r_ky + 16'd1;
            end else begin
              r_ky <= '0;
              if (r_ci != CI_LAST) begin
                r_ci <= r_ci + 16'd1;
              end else begin
                // Last tap of this pixel: capture the formatted result.
                r_ci       <= '0;
                r_out_data <= w_result;
                r_out_ch   <= r_co;
                r_out_y    <= r_oy;
                r_out_x    <= r_ox;
                r_state    <= S_EMIT;
              end
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_state <= S_MAC;
            if (r_ox != O_LAST) begin
              r_ox <= r_ox + 16'd1;
            end else begin
              r_ox <= '0;
              if (r_oy != O_LAST) begin
                r_oy <= r_oy + 16'd1;
              end else begin
                r_oy <= '0;
                if (r_co != CO_LAST) begin
                  r_co <= r_co + 16'd1;
                end else begin
                  r_co    <= '0;
                  r_state <= S_DONE;
                end
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_MAC) || (r_state == S_EMIT);
  assign done      = (r_state == S_DONE);
  assign out_valid = (r_state == S_EMIT);
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_y     = r_out_y;
  assign out_x     = r_out_x;

endmodule

// File: tb/tb_conv2d_engine.sv
`timescale 1ns/1ps
// tb_conv2d_engine: three engine instances (defaults, RELU=0, stride-2 single
// channel) driven by directed loads and runs. An arithmetic reference model
// produces the expected result stream; a negedge process compares every
// valid output cycle against it.
module tb_conv2d_engine;

  typedef struct {
    logic [15:0] ch;
    logic [15:0] y;
    logic [15:0] x;
    logic [15:0] data;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en [3];
  logic        wr_sel [3];
  logic [15:0] wr_addr [3];
  logic [15:0] wr_data [3];
  logic        start [3];
  logic        out_ready [3];
  logic        busy [3];
  logic        done [3];
  logic        out_valid [3];
  logic [15:0] out_data [3];
  logic [15:0] out_ch [3];
  logic [15:0] out_y [3];
  logic [15:0] out_x [3];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   hs_cnt [3];
  int   stall_cnt [3];
  int   bp_idx = 0;
  int   bp_len = 0;
  logic prev_v [3];
  logic prev_r [3];

  int   m_act [3][50];
  int   m_w [3][36];
  res_t exp_q [3][$];
  logic [15:0] got_q [3][$];

  always #5 clk = ~clk;

  conv2d_engine u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_sel(wr_sel[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_ch(out_ch[0]), .out_y(out_y[0]), .out_x(out_x[0]));

  conv2d_engine #(.RELU(0)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_sel(wr_sel[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_ch(out_ch[1]), .out_y(out_y[1]), .out_x(out_x[1]));

  conv2d_engine #(.STRIDE(2), .NUM_INPUTS(1), .NUM_OUTPUTS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_sel(wr_sel[2]), .wr_addr(wr_addr[2]),
    .wr_data(wr_data[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_ch(out_ch[2]), .out_y(out_y[2]), .out_x(out_x[2]));

  // Per-instance configuration (input side 5 and kernel 3 everywhere).
  function automatic int cfg_ni(input int i);   return (i == 2) ? 1 : 2; endfunction
  function automatic int cfg_no(input int i);   return (i == 2) ? 1 : 2; endfunction
  function automatic int cfg_s(input int i);    return (i == 2) ? 2 : 1; endfunction
  function automatic int cfg_relu(input int i); return (i == 1) ? 0 : 1; endfunction
  function automatic int cfg_od(input int i);   return (5 - 3) / cfg_s(i) + 1; endfunction

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s u%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  // Reference model: full convolution per output pixel in channel-major order.
  task automatic build_expected(input int i);
    res_t   e;
    longint acc;
    longint r;
    int     s;
    int     ni;
    s  = cfg_s(i);
    ni = cfg_ni(i);
    exp_q[i].delete();
    for (int co = 0; co < cfg_no(i); co++)
      for (int oy = 0; oy < cfg_od(i); oy++)
        for (int ox = 0; ox < cfg_od(i); ox++) begin
          acc = 0;
          for (int ci = 0; ci < ni; ci++)
            for (int ky = 0; ky < 3; ky++)
              for (int kx = 0; kx < 3; kx++)
                acc += longint'(m_act[i][ci*25 + (oy*s + ky)*5 + ox*s + kx])
                     * longint'(m_w[i][((co*ni + ci)*3 + ky)*3 + kx]);
          r = acc >>> 8;
          if (r > 32767) r = 32767;
          if (r < -32768) r = -32768;
          if (cfg_relu(i) != 0 && r < 0) r = 0;
          e.ch   = 16'(co);
          e.y    = 16'(oy);
          e.x    = 16'(ox);
          e.data = 16'(r);
          exp_q[i].push_back(e);
        end
  endtask

  // Output checker: every valid cycle is compared against the head of the model queue.
  always @(negedge clk) begin : compare
    res_t e;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        prev_v[i] = 1'b0;
        prev_r[i] = 1'b1;
      end else begin
        if (start[i]) begin
          hs_cnt[i]    = 0;
          stall_cnt[i] = 0;
          got_q[i].delete();
        end
        if (prev_v[i] && !prev_r[i]) check("valid_held", i, 64'(out_valid[i]), 64'd1);
        if (out_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            check("extra_result", i, 64'(out_valid[i]), 64'd0);
          end else begin
            e = exp_q[i][0];
            check("data", i, 64'(out_data[i]), 64'(e.data));
            check("ch", i, 64'(out_ch[i]), 64'(e.ch));
            check("y", i, 64'(out_y[i]), 64'(e.y));
            check("x", i, 64'(out_x[i]), 64'(e.x));
            if (out_ready[i]) begin
              void'(exp_q[i].pop_front());
              got_q[i].push_back(out_data[i]);
              hs_cnt[i]++;
            end else begin
              stall_cnt[i]++;
            end
          end
        end
        prev_v[i] = out_valid[i];
        prev_r[i] = out_ready[i];
      end
    end
  end

  // Consumer: always ready except for a programmed stall on instance 0.
  initial begin : ready_drv
    for (int i = 0; i < 3; i++) out_ready[i] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_len > 0 && hs_cnt[0] == bp_idx && out_valid[0]) begin
        out_ready[0] = 1'b0;
        bp_len--;
      end else begin
        out_ready[0] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int mask, input bit sel, input int addr,
                            input logic [15:0] data, input bit upd);
    for (int i = 0; i < 3; i++)
      if (mask[i]) begin
        wr_en[i]   = 1'b1;
        wr_sel[i]  = sel;
        wr_addr[i] = 16'(addr);
        wr_data[i] = data;
        if (upd && !sel && addr < cfg_ni(i) * 25) m_act[i][addr] = int'($signed(data));
        if (upd && sel && addr < cfg_no(i) * cfg_ni(i) * 9) m_w[i][addr] = int'($signed(data));
      end
    tick();
    for (int i = 0; i < 3; i++) wr_en[i] = 1'b0;
  endtask

  task automatic load_acts(input int mask, input int n, input logic [15:0] v);
    for (int a = 0; a < n; a++) write_word(mask, 1'b0, a, v, 1'b1);
  endtask

  task automatic load_wgts(input int mask, input int n, input logic [15:0] v);
    for (int a = 0; a < n; a++) write_word(mask, 1'b1, a, v, 1'b1);
  endtask

  task automatic start_run(input int mask);
    for (int i = 0; i < 3; i++)
      if (mask[i]) begin
        build_expected(i);
        start[i] = 1'b1;
      end
    tick();
    t0 = cyc;
    for (int i = 0; i < 3; i++)
      if (mask[i]) begin
        start[i] = 1'b0;
        check("busy_after_start", i, 64'(busy[i]), 64'd1);
      end
  endtask

  task automatic wait_done(input int mask, input int exp_lat);
    int first [3];
    int cnt [3];
    for (int i = 0; i < 3; i++) begin
      first[i] = -1;
      cnt[i]   = 0;
    end
    while (cyc - t0 < exp_lat + 6) begin
      tick();
      for (int i = 0; i < 3; i++)
        if (mask[i] && done[i]) begin
          cnt[i]++;
          if (first[i] < 0) first[i] = cyc - t0;
          check("busy_during_done", i, 64'(busy[i]), 64'd0);
        end
    end
    for (int i = 0; i < 3; i++)
      if (mask[i]) begin
        check("done_latency", i, 64'(first[i]), 64'(exp_lat));
        check("done_count", i, 64'(cnt[i]), 64'd1);
        check("results_left", i, 64'(exp_q[i].size()), 64'd0);
        check("busy_after_done", i, 64'(busy[i]), 64'd0);
      end
  endtask

  task automatic check_reset_outputs(input int i);
    check("rst_busy", i, 64'(busy[i]), 64'd0);
    check("rst_done", i, 64'(done[i]), 64'd0);
    check("rst_valid", i, 64'(out_valid[i]), 64'd0);
    check("rst_data", i, 64'(out_data[i]), 64'd0);
    check("rst_ch", i, 64'(out_ch[i]), 64'd0);
    check("rst_y", i, 64'(out_y[i]), 64'd0);
    check("rst_x", i, 64'(out_x[i]), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en[i]   = 1'b0;
      wr_sel[i]  = 1'b0;
      wr_addr[i] = '0;
      wr_data[i] = '0;
      start[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #3;
    for (int i = 0; i < 3; i++) check_reset_outputs(i);
    rst_n = 1'b1;
    tick();

    // All ones: every pixel sums 18 products of 1.0.
    load_acts(3, 50, 16'h0100);
    load_wgts(3, 36, 16'h0100);
    start_run(3);
    wait_done(3, 342);
    for (int i = 0; i < 2; i++) begin
      check("ones_count", i, 64'(got_q[i].size()), 64'd18);
      check("ones_first", i, 64'(got_q[i][0]), 64'h1200);
      check("ones_last", i, 64'(got_q[i][17]), 64'h1200);
      check("last_ch", i, 64'(out_ch[i]), 64'd1);
      check("last_y", i, 64'(out_y[i]), 64'd2);
      check("last_x", i, 64'(out_x[i]), 64'd2);
    end

    // Backpressure: five stalled cycles on the third result of u0.
    bp_idx = 2;
    bp_len = 5;
    start_run(1);
    wait_done(1, 347);
    check("stall_cycles", 0, 64'(stall_cnt[0]), 64'd5);
    check("bp_count", 0, 64'(got_q[0].size()), 64'd18);
    check("bp_third", 0, 64'(got_q[0][2]), 64'h1200);

    // Asynchronous reset in the middle of pixel 4 accumulation.
    start_run(1);
    repeat (84) tick();
    check("mid_mac_busy", 0, 64'(busy[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    exp_q[0].delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    start_run(1);
    wait_done(1, 342);
    check("rerun_count", 0, 64'(got_q[0].size()), 64'd18);

    // Writes and start while busy are ignored.
    start_run(1);
    repeat (30) tick();
    write_word(1, 1'b1, 0, 16'h0000, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(1, 342);
    start_run(1);
    wait_done(1, 342);
    check("after_busy_wr_first", 0, 64'(got_q[0][0]), 64'h1200);

    // Saturation on both instances.
    load_acts(3, 50, 16'h6400);
    load_wgts(3, 36, 16'h6400);
    start_run(3);
    wait_done(3, 342);
    check("sat_pos", 0, 64'(got_q[0][0]), 64'h7FFF);
    check("sat_pos", 1, 64'(got_q[1][17]), 64'h7FFF);

    // Negative weights: ReLU clamps to zero, otherwise saturates low.
    load_wgts(3, 36, 16'h9C00);
    start_run(3);
    wait_done(3, 342);
    check("neg_relu", 0, 64'(got_q[0][0]), 64'h0000);
    check("neg_norelu", 1, 64'(got_q[1][0]), 64'h8000);

    // Stride 2: centre tap picks activations (1,1),(1,3),(3,1),(3,3).
    for (int a = 0; a < 25; a++) write_word(4, 1'b0, a, 16'(a << 8), 1'b1);
    for (int a = 0; a < 9; a++) write_word(4, 1'b1, a, (a == 4) ? 16'h0100 : 16'h0000, 1'b1);
    start_run(4);
    wait_done(4, 40);
    check("s2_count", 2, 64'(got_q[2].size()), 64'd4);
    if (got_q[2].size() == 4) begin
      check("s2_p0", 2, 64'(got_q[2][0]), 64'h0600);
      check("s2_p1", 2, 64'(got_q[2][1]), 64'h0800);
      check("s2_p2", 2, 64'(got_q[2][2]), 64'h1000);
      check("s2_p3", 2, 64'(got_q[2][3]), 64'h1200);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
